// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcodes, FSM encoding and
// default latencies.
package mdu_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam int unsigned DefMultCycles = 5;
    localparam int unsigned DefDivCycles  = 10;

endpackage

// File: rtl/mdu_ctrl_if.sv
// Execute-stage <-> MDU signal bundle; master is the pipeline, slave is the MDU.
interface mdu_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             md_start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             md_use_d;
    logic             hilo_sel;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             stall;

    modport master (
        output md_start, md_op, rs_val, rt_val, md_use_d, hilo_sel,
        input  rd_data, busy, stall
    );

    modport slave (
        input  md_start, md_op, rs_val, rt_val, md_use_d, hilo_sel,
        output rd_data, busy, stall
    );

endinterface

// File: rtl/mdu_alu.sv
// Combinational signed/unsigned multiply and divide producing {hi, lo}; flags a zero
// divisor on divide ops.
module mdu_alu
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic                      is_signed_div;
    logic                      a_neg, b_neg;
    logic        [WIDTH-1:0]   dvd, dvs, quot_mag, rem_mag, quot, rem;

    assign prod_s = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
    assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    // Signed divide works on magnitudes; MIN / -1 then falls out as MIN rem 0.
    assign is_signed_div = (op_i == MD_DIV);
    assign a_neg         = is_signed_div & a_i[WIDTH-1];
    assign b_neg         = is_signed_div & b_i[WIDTH-1];
    assign dvd           = a_neg ? (~a_i + 1'b1) : a_i;
    assign dvs           = (b_i == '0) ? {{(WIDTH-1){1'b0}}, 1'b1}
                                       : (b_neg ? (~b_i + 1'b1) : b_i);
    assign quot_mag      = dvd / dvs;
    assign rem_mag       = dvd % dvs;
    assign quot          = (a_neg ^ b_neg) ? (~quot_mag + 1'b1) : quot_mag;
    assign rem           = a_neg ? (~rem_mag + 1'b1) : rem_mag;

    always_comb begin
        hi_o       = '0;
        lo_o       = '0;
        div_zero_o = 1'b0;
        case (op_i)
            MD_MULT: begin
                hi_o = prod_s[2*WIDTH-1:WIDTH];
                lo_o = prod_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                hi_o = prod_u[2*WIDTH-1:WIDTH];
                lo_o = prod_u[WIDTH-1:0];
            end
            MD_DIV, MD_DIVU: begin
                hi_o       = rem;
                lo_o       = quot;
                div_zero_o = (b_i == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models a fixed busy window per operation and
// raises the decode-stage stall.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = DefMultCycles,
    parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
    input logic       clk_i,
    input logic       reset_i,
    mdu_ctrl_if.slave md
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [0:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] hi_nx_q, hi_nx_d, lo_nx_q, lo_nx_d;
    logic [WIDTH-1:0] alu_hi, alu_lo;
    logic             alu_div_zero;
    logic             is_mul, is_div;

    mdu_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i       (md.md_op),
        .a_i        (md.rs_val),
        .b_i        (md.rt_val),
        .hi_o       (alu_hi),
        .lo_o       (alu_lo),
        .div_zero_o (alu_div_zero)
    );

    assign is_mul = (md.md_op == MD_MULT) | (md.md_op == MD_MULTU);
    assign is_div = (md.md_op == MD_DIV)  | (md.md_op == MD_DIVU);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_nx_d = hi_nx_q;
        lo_nx_d = lo_nx_q;
        case (state_q)
            StIdle: begin
                if (md.md_start) begin
                    if (is_mul | is_div) begin
                        state_d = StRun;
                        cnt_d   = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                        // HI/LO cannot change while running, so a zero divisor just
                        // re-commits the current values.
                        hi_nx_d = alu_div_zero ? hi_q : alu_hi;
                        lo_nx_d = alu_div_zero ? lo_q : alu_lo;
                    end else if (md.md_op == MD_MTHI) begin
                        hi_d = md.rs_val;
                    end else if (md.md_op == MD_MTLO) begin
                        lo_d = md.rs_val;
                    end
                end
            end
            StRun: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    hi_d    = hi_nx_q;
                    lo_d    = lo_nx_q;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_nx_q <= '0;
            lo_nx_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_nx_q <= hi_nx_d;
            lo_nx_q <= lo_nx_d;
        end
    end

    assign md.rd_data = md.hilo_sel ? hi_q : lo_q;
    assign md.busy    = (state_q == StRun);
    assign md.stall   = md.md_use_d & (md.md_start | (state_q == StRun));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed scenarios plus random traffic against a cycle-level
// reference model built from plain 64-bit arithmetic.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_ctrl_if #(.WIDTH(W)) md_if ();

    mdu_ctrl #(
        .WIDTH       (W),
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .md      (md_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    logic [31:0] o_rd;
    logic        o_busy, o_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      q, r, ps;
        logic [63:0] pu;
        sa = a;
        sb = b;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (st) begin
            case (op)
                3'd0: begin
                    ps = longint'(sa) * longint'(sb);
                    p_hi = ps[63:32]; p_lo = ps[31:0]; m_left = MC;
                end
                3'd1: begin
                    pu = {32'h0, a} * {32'h0, b};
                    p_hi = pu[63:32]; p_lo = pu[31:0]; m_left = MC;
                end
                3'd2: begin
                    p_hi = m_hi; p_lo = m_lo;
                    if (b != 0) begin
                        q = longint'(sa) / longint'(sb);
                        r = longint'(sa) % longint'(sb);
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end
                    m_left = DC;
                end
                3'd3: begin
                    p_hi = m_hi; p_lo = m_lo;
                    if (b != 0) begin
                        p_lo = a / b; p_hi = a % b;
                    end
                    m_left = DC;
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive, check outputs at the falling edge, advance the model.
    task automatic cyc(input logic rst, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic use_d, input logic sel);
        reset           = rst;
        md_if.md_start  = st;
        md_if.md_op     = op;
        md_if.rs_val    = a;
        md_if.rt_val    = b;
        md_if.md_use_d  = use_d;
        md_if.hilo_sel  = sel;
        @(negedge clk);
        o_rd    = md_if.rd_data;
        o_busy  = md_if.busy;
        o_stall = md_if.stall;
        check("busy", {31'b0, o_busy}, {31'b0, m_left > 0});
        check("stall", {31'b0, o_stall}, {31'b0, use_d & (st | (m_left > 0))});
        check("rd_data", o_rd, sel ? m_hi : m_lo);
        @(posedge clk);
        model_edge(rst, st, op, a, b);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    int stall_cnt;

    initial begin
        reset = 1'b1;
        md_if.md_start = 1'b0; md_if.md_op = '0; md_if.rs_val = '0; md_if.rt_val = '0;
        md_if.md_use_d = 1'b0; md_if.hilo_sel = 1'b0;
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; m_left = 0;
        repeat (2) @(posedge clk);
        #1;

        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        check("rst_lo", o_rd, 32'h0);
        check("rst_busy", {31'b0, o_busy}, 32'h0);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        check("rst_hi", o_rd, 32'h0);

        // MULT -2 x 3 with a D-stage MDU instruction waiting
        cyc(1'b0, 1'b1, MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
        check("stall_launch", {31'b0, o_stall}, 32'h1);
        stall_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
            stall_cnt += int'(o_stall);
        end
        check("stall_cnt", stall_cnt, 32'd5);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b1, 1'b1);
        check("stall_after", {31'b0, o_stall}, 32'h0);
        check("mult_hi", o_rd, 32'hFFFFFFFF);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        check("mult_lo", o_rd, 32'hFFFFFFFA);

        // MULTU with an MTLO arriving mid-run that must be dropped
        cyc(1'b0, 1'b1, MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, MD_MTLO, 32'h1234, '0, 1'b0, 1'b0);
        check("stall_nouse", {31'b0, o_stall}, 32'h0);
        idle(3);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        check("multu_hi", o_rd, 32'h2);
        check("multu_idle", {31'b0, o_busy}, 32'h0);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        check("multu_lo", o_rd, 32'hFFFFFFFA);

        // DIV -7 / 2
        cyc(1'b0, 1'b1, MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        idle(DC);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        check("div_lo", o_rd, 32'hFFFFFFFD);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        check("div_hi", o_rd, 32'hFFFFFFFF);

        // DIVU by zero leaves HI/LO alone
        cyc(1'b0, 1'b1, MD_DIVU, 32'd7, 32'd0, 1'b0, 1'b0);
        idle(DC);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        check("div0_lo", o_rd, 32'hFFFFFFFD);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        check("div0_hi", o_rd, 32'hFFFFFFFF);

        // MTHI in idle
        cyc(1'b0, 1'b1, MD_MTHI, 32'hDEADBEEF, '0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        check("mthi", o_rd, 32'hDEADBEEF);
        check("mthi_busy", {31'b0, o_busy}, 32'h0);

        // Reset in the third busy cycle of a DIV
        cyc(1'b0, 1'b1, MD_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(2);
        cyc(1'b1, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        check("abort_busy", {31'b0, o_busy}, 32'h0);
        check("abort_hi", o_rd, 32'h0);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        check("abort_lo", o_rd, 32'h0);
        cyc(1'b0, 1'b1, MD_MULT, 32'd4, 32'd5, 1'b0, 1'b0);
        idle(MC);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        check("post_lo", o_rd, 32'd20);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        check("post_hi", o_rd, 32'd0);

        // Random traffic, including starts while busy, reserved ops and corner operands
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            cyc(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 2) == 0),
                3'($urandom_range(0, 7)), a, b,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
